// File: rtl/serial_to_parallel_converter.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_converter
//   Assembles WIDTH serial bits (LSB first) into a parallel word and holds it
//   in an output register with a valid/ready handshake. A word that completes
//   while the holding register is full and not being drained is dropped and
//   raises a sticky overflow flag.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   serial_i    serial data bit, LSB of each word first
//   valid_i     serial_i is valid this cycle
//   ready_i     downstream accepts parallel_o this cycle
//   clr_ovf_i   synchronous clear of overflow_o (a coincident drop wins)
//   parallel_o  assembled word holding register
//   valid_o     parallel_o holds an unconsumed word
//   busy_o      partial word in progress (bit counter nonzero)
//   overflow_o  sticky flag: a completed word was dropped
// -----------------------------------------------------------------------------
module serial_to_parallel_converter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] par_d;
    logic             vld_d;
    logic             ovf_d;
    logic [WIDTH-1:0] shift_nx;
    logic             complete;
    logic             drop;

    // Next-state logic for the assembler and the holding register.
    always_comb begin
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = parallel_o;
        vld_d    = valid_o;
        ovf_d    = overflow_o;
        shift_nx = {serial_i, shift_q[WIDTH-1:1]};
        complete = valid_i && (cnt_q == LAST);
        // Holding register full and not drained on this edge: the word is lost.
        drop     = complete && valid_o && !ready_i;

        if (valid_i) begin
            shift_d = shift_nx;
            cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
        end

        // A completing word takes priority over a plain transfer (no bubble).
        if (complete && !drop) begin
            par_d = shift_nx;
            vld_d = 1'b1;
        end else if (valid_o && ready_i) begin
            vld_d = 1'b0;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            parallel_o <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            parallel_o <= par_d;
            valid_o    <= vld_d;
            overflow_o <= ovf_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel_converter
//   Directed scenarios with fixed expected words plus a randomized run checked
//   against a queue-based reference model of the converter.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel_converter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             serial_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    logic             clr_ovf_i = 1'b0;
    logic [WIDTH-1:0] parallel_o;
    logic             valid_o;
    logic             busy_o;
    logic             overflow_o;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    bit               m_bits[$];
    logic [WIDTH-1:0] m_hold;
    bit               m_val;
    bit               m_ovf;

    serial_to_parallel_converter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_i   (serial_i),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .clr_ovf_i  (clr_ovf_i),
        .parallel_o (parallel_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_bits.delete();
        m_hold = '0;
        m_val  = 0;
        m_ovf  = 0;
    endtask

    // One rising edge of the reference model using the inputs sampled there.
    task automatic model_step(input bit v, input bit s, input bit r, input bit c);
        bit               done;
        bit               dropped;
        logic [WIDTH-1:0] word;
        done    = 0;
        dropped = 0;
        word    = '0;
        if (v) begin
            m_bits.push_back(s);
            if (m_bits.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) word[i] = m_bits[i];
                m_bits.delete();
                done = 1;
            end
        end
        if (done && (!m_val || r)) begin
            m_hold = word;
            m_val  = 1;
        end else if (done) begin
            dropped = 1;
        end else if (m_val && r) begin
            m_val = 0;
        end
        if (dropped) m_ovf = 1;
        else if (c)  m_ovf = 0;
    endtask

    // Drive inputs, take one edge, update the model, settle before checking.
    task automatic tick(input bit v, input bit s, input bit r, input bit c);
        valid_i   = v;
        serial_i  = s;
        ready_i   = r;
        clr_ovf_i = c;
        @(posedge clk);
        if (reset) model_step(v, s, r, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        valid_i  = 1'b1;
        serial_i = 1'b1;
        ready_i  = 1'b0;
        reset    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({parallel_o, valid_o, busy_o, overflow_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_held: got par=%h v=%b b=%b o=%b want all 0",
                     parallel_o, valid_o, busy_o, overflow_o);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        checks++;
        if ({parallel_o, valid_o, busy_o, overflow_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_release: got par=%h v=%b b=%b o=%b want all 0",
                     parallel_o, valid_o, busy_o, overflow_o);
        end
        // Asynchronous assertion between edges clears state immediately.
        tick(1, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got busy=%b want 0", busy_o);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        bit b[4] = '{1, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_o !== 1'b0) begin
                failures++;
                $display("FAIL basic_early_valid: bit %0d got valid=%b want 0", i, valid_o);
            end
            tick(1, b[i], 1, 0);
        end
        checks++;
        if (valid_o !== 1'b1 || parallel_o !== 4'hD || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_word: got par=%h v=%b busy=%b want D 1 0",
                     parallel_o, valid_o, busy_o);
        end
        tick(0, 0, 1, 0);
        checks++;
        if (valid_o !== 1'b0 || parallel_o !== 4'hD) begin
            failures++;
            $display("FAIL basic_one_cycle: got par=%h v=%b want D 0", parallel_o, valid_o);
        end
    endtask

    task automatic test_gap();
        do_reset();
        tick(1, 0, 1, 0);
        tick(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 0);
            checks++;
            if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
                failures++;
                $display("FAIL gap_busy: cycle %0d got busy=%b v=%b want 1 0", i, busy_o, valid_o);
            end
        end
        tick(1, 1, 1, 0);
        tick(1, 0, 1, 0);
        checks++;
        if (parallel_o !== 4'h6 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL gap_word: got par=%h v=%b want 6 1", parallel_o, valid_o);
        end
    endtask

    task automatic test_overflow();
        bit wa[4] = '{0, 1, 0, 1};
        bit w5[4] = '{1, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, wa[i], 0, 0);
        for (int i = 0; i < 4; i++) tick(1, w5[i], 0, 0);
        checks++;
        if (parallel_o !== 4'hA || valid_o !== 1'b1 || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: got par=%h v=%b o=%b want A 1 1",
                     parallel_o, valid_o, overflow_o);
        end
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b1 || parallel_o !== 4'hA) begin
            failures++;
            $display("FAIL ovf_sticky: got par=%h v=%b o=%b want A 0 1",
                     parallel_o, valid_o, overflow_o);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got o=%b want 0", overflow_o);
        end
        // Drop coincident with clear: set wins.
        for (int i = 0; i < 4; i++) tick(1, w5[i], 0, 0);
        for (int i = 0; i < 3; i++) tick(1, wa[i], 0, 0);
        tick(1, wa[3], 0, 1);
        checks++;
        if (overflow_o !== 1'b1 || parallel_o !== 4'h5) begin
            failures++;
            $display("FAIL ovf_set_wins: got par=%h o=%b want 5 1", parallel_o, overflow_o);
        end
        tick(0, 0, 1, 1);
    endtask

    task automatic test_back_to_back();
        bit w3[4] = '{1, 1, 0, 0};
        bit wc[4] = '{0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, w3[i], 0, 0);
        checks++;
        if (parallel_o !== 4'h3 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: got par=%h v=%b want 3 1", parallel_o, valid_o);
        end
        for (int i = 0; i < 3; i++) tick(1, wc[i], 0, 0);
        tick(1, wc[3], 1, 0);
        checks++;
        if (parallel_o !== 4'hC || valid_o !== 1'b1 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got par=%h v=%b o=%b want C 1 0",
                     parallel_o, valid_o, overflow_o);
        end
        tick(0, 0, 1, 0);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got v=%b want 0", valid_o);
        end
    endtask

    task automatic test_reset_midword();
        bit w3[4] = '{1, 1, 0, 0};
        do_reset();
        tick(1, 1, 1, 0);
        tick(1, 0, 1, 0);
        do_reset();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL midword_busy: got busy=%b want 0", busy_o);
        end
        for (int i = 0; i < 4; i++) tick(1, w3[i], 1, 0);
        checks++;
        if (parallel_o !== 4'h3 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL midword_word: got par=%h v=%b want 3 1", parallel_o, valid_o);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
            checks++;
            if (valid_o !== m_val || overflow_o !== m_ovf ||
                busy_o !== (m_bits.size() != 0) || parallel_o !== m_hold) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle %0d: got par=%h v=%b b=%b o=%b want %h %b %b %b",
                             n, parallel_o, valid_o, busy_o, overflow_o,
                             m_hold, m_val, (m_bits.size() != 0), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_overflow();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_converter.md
SERIAL_TO_PARALLEL_CONVERTER -- requirements
Module: serial_to_parallel_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, 4, number of serial bits per assembled word (legal range 2..16).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have port clk  input  1  clock; every flop updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port serial_i  input  1  serial data bit, LSB of each word first.
REQ-006 The block SHALL have port valid_i  input  1  serial_i carries a valid bit this cycle.
REQ-007 The block SHALL have port ready_i  input  1  downstream accepts parallel_o this cycle.
REQ-008 The block SHALL have port clr_ovf_i  input  1  synchronous clear of overflow_o.
REQ-009 The block SHALL have port parallel_o  output  WIDTH  assembled word holding register.
REQ-010 The block SHALL have port valid_o  output  1  parallel_o holds an unconsumed word.
REQ-011 The block SHALL have port busy_o  output  1  partial word in progress (bit count nonzero).
REQ-012 The block SHALL have port overflow_o  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 The block SHALL keep a bit counter of width clog2(WIDTH) and a WIDTH-bit shift register; both SHALL advance only on edges where valid_i=1.
REQ-014 On each valid edge the shift register SHALL load {serial_i, shift[WIDTH-1:1]}, so the first bit received ends in bit 0.
REQ-015 The counter SHALL count 0..WIDTH-1 and wrap to 0 on the edge that samples the last bit; the wrap SHALL NOT depend on any other input.
REQ-016 busy_o SHALL equal (counter != 0), combinationally from the counter flop.
REQ-017 On the completing edge (valid_i=1, counter=WIDTH-1) the word {serial_i, shift[WIDTH-1:1]} SHALL load into parallel_o at that same edge if the holding register is free or is being consumed (valid_o=1 and ready_i=1) on that edge.
REQ-018 valid_o SHALL be 1 in the cycle after the load (one-cycle latency from the last bit) and SHALL remain 1, with parallel_o stable, until an edge with ready_i=1.
REQ-019 A transfer SHALL occur on an edge with valid_o=1 and ready_i=1; with no simultaneous completing word, valid_o SHALL drop to 0 and parallel_o SHALL keep its last value.
REQ-020 Simultaneous transfer and completing word SHALL load the new word and keep valid_o=1 (back-to-back, no bubble).
REQ-021 A completing word while valid_o=1 and ready_i=0 SHALL be dropped, parallel_o SHALL remain unchanged, and overflow_o SHALL be set to 1 from the next cycle.
REQ-022 overflow_o SHALL remain 1 until an edge with clr_ovf_i=1; a drop coincident with clr_ovf_i=1 SHALL leave overflow_o=1 (set wins).
REQ-023 ready_i SHALL be ignored while valid_o=0; valid_i=0 SHALL freeze counter and shift register.

Reset
REQ-024 While reset=0 the block SHALL immediately force counter=0, shift register=0, parallel_o=0, valid_o=0, busy_o=0 and overflow_o=0, independent of clk.
REQ-025 Reset asserted mid-word SHALL discard the partial word; the first valid bit after release SHALL be bit 0 of a new word.
REQ-026 The first rising edge with reset=1 SHALL operate normally; no input is sampled while reset=0.

Verification (WIDTH=4)
REQ-027 Reset: drive reset=0 with valid_i=1 -> all outputs 0, busy_o=0; after release with valid_i=0, outputs stay 0.
REQ-028 Basic: serial_i 1,0,1,1 on consecutive valid edges, ready_i=1 -> parallel_o=4'hD, valid_o=1 for exactly one cycle, one cycle after the fourth bit.
REQ-029 Gapped input: bits 0,1, then valid_i=0 for 3 cycles, then bits 1,0 -> busy_o=1 across the gap, parallel_o=4'h6.
REQ-030 Backpressure/overflow: word 4'hA with ready_i=0, then word 4'h5 completes -> parallel_o stays 4'hA, overflow_o=1; ready_i=1 -> valid_o=0, overflow_o stays 1 until clr_ovf_i=1.
REQ-031 Simultaneous: valid_o=1 with 4'h3, ready_i=1 on the edge word 4'hC completes -> parallel_o=4'hC, valid_o remains 1.
REQ-032 Reset mid-word: reset after 2 bits, then bits 1,1,0,0 -> parallel_o=4'h3, no remnant of the old bits.
